// File: rtl/game_sequencer.sv
// Game-flow controller: slow tick divider, jump/scroll phase counters, the
// IDLE/PLAY/SCROLL/OVER state machine and lowest-platform ring bookkeeping.
module game_sequencer #(
    parameter int TICK_DIV     = 3000000,
    parameter int JUMP_TICKS   = 14,
    parameter int SCROLL_TICKS = 3,
    parameter int JT_W         = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            land,
    input  logic [1:0]      land_id,
    input  logic            fall_out,
    output logic            tick,
    output logic [JT_W-1:0] jump_t,
    output logic            falling,
    output logic            scroll_en,
    output logic [1:0]      scroll_t,
    output logic [1:0]      lowest_id,
    output logic            respawn,
    output logic [1:0]      respawn_id,
    output logic [1:0]      state,
    output logic            game_over
);
    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [JT_W-1:0] JT_MAX = {JT_W{1'b1}};

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, SCROLL = 2'd2, OVER = 2'd3} state_t;

    state_t          cur, nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt, div_wrap;
    logic [JT_W-1:0]  jt_nxt, jt_adv;
    logic [1:0]       st_nxt, low_nxt, tgt_nxt, rid_nxt, target;
    logic             first, first_nxt, resp_nxt;
    logic             running, land_ok, rebounce, scroll_done;

    assign running     = (cur == PLAY) || (cur == SCROLL);
    assign tick        = running && (div_cnt == DIV_W'(TICK_DIV - 1));
    assign div_wrap    = tick ? '0 : div_cnt + 1'b1;
    assign falling     = jump_t >= JT_W'(JUMP_TICKS / 2);
    assign scroll_en   = (cur == SCROLL);
    assign game_over   = (cur == OVER);
    assign state       = cur;
    assign scroll_done = (scroll_t == 2'(SCROLL_TICKS - 1));

    // Before the first scroll the doodle bounces on the ground: the arc wraps
    // at JUMP_TICKS. Afterwards it keeps counting up and saturates.
    assign jt_adv = (first && jump_t == JT_W'(JUMP_TICKS)) ? '0 :
                    (jump_t == JT_MAX) ? JT_MAX : jump_t + 1'b1;

    // Only the standing platform (rebounce) or the next one up the ring counts.
    assign rebounce = !first && (land_id == lowest_id);
    assign land_ok  = falling &&
                      ((land_id == lowest_id) || (!first && land_id == 2'(lowest_id + 2'd1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur        <= IDLE;
            div_cnt    <= '0;
            jump_t     <= '0;
            scroll_t   <= '0;
            lowest_id  <= '0;
            target     <= '0;
            first      <= 1'b1;
            respawn    <= 1'b0;
            respawn_id <= '0;
        end else begin
            cur        <= nxt;
            div_cnt    <= div_nxt;
            jump_t     <= jt_nxt;
            scroll_t   <= st_nxt;
            lowest_id  <= low_nxt;
            target     <= tgt_nxt;
            first      <= first_nxt;
            respawn    <= resp_nxt;
            respawn_id <= rid_nxt;
        end
    end

    always_comb begin
        nxt       = cur;
        div_nxt   = div_cnt;
        jt_nxt    = jump_t;
        st_nxt    = scroll_t;
        low_nxt   = lowest_id;
        tgt_nxt   = target;
        first_nxt = first;
        resp_nxt  = 1'b0;
        rid_nxt   = respawn_id;
        case (cur)
            IDLE, OVER: begin
                if (start) begin
                    nxt       = PLAY;
                    div_nxt   = '0;
                    jt_nxt    = '0;
                    st_nxt    = '0;
                    low_nxt   = '0;
                    first_nxt = 1'b1;
                end
            end
            PLAY: begin
                if (fall_out) begin
                    nxt     = OVER;
                    div_nxt = '0;
                end else if (land && land_ok) begin
                    jt_nxt  = '0;
                    div_nxt = '0;
                    st_nxt  = '0;
                    if (!rebounce) begin
                        nxt     = SCROLL;
                        tgt_nxt = land_id;
                    end
                end else begin
                    div_nxt = div_wrap;
                    if (tick) jt_nxt = jt_adv;
                end
            end
            SCROLL: begin
                if (fall_out) begin
                    nxt     = OVER;
                    div_nxt = '0;
                end else begin
                    div_nxt = div_wrap;
                    if (tick) begin
                        jt_nxt = jt_adv;
                        if (scroll_done) begin
                            st_nxt    = 2'(SCROLL_TICKS);
                            nxt       = PLAY;
                            low_nxt   = target;
                            first_nxt = 1'b0;
                            // The very first scroll only lifts off the ground.
                            if (!first) begin
                                resp_nxt = 1'b1;
                                rid_nxt  = lowest_id;
                            end
                        end else begin
                            st_nxt = scroll_t + 2'd1;
                        end
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_game_sequencer.sv
// Directed scenario steps plus randomized play, checked every cycle against a
// behavioural model of the game rules.
module tb_game_sequencer;
    localparam int TD = 4;
    localparam int JT = 14;
    localparam int ST = 3;
    localparam int JW = 6;
    localparam int JMAX = 63;

    logic clk, rst, start, land, fall_out;
    logic [1:0] land_id, scroll_t, lowest_id, respawn_id, state;
    logic [JW-1:0] jump_t;
    logic tick, falling, scroll_en, respawn, game_over;

    int n_tests = 0;
    int n_fail = 0;

    // model state: mode 0 idle, 1 play, 2 scroll, 3 over
    int m_mode, m_div, m_jt, m_st, m_low, m_tgt, m_rid;
    bit m_first, m_resp;

    game_sequencer #(.TICK_DIV(TD), .JUMP_TICKS(JT), .SCROLL_TICKS(ST), .JT_W(JW)) dut (
        .clk(clk), .rst(rst), .start(start), .land(land), .land_id(land_id),
        .fall_out(fall_out), .tick(tick), .jump_t(jump_t), .falling(falling),
        .scroll_en(scroll_en), .scroll_t(scroll_t), .lowest_id(lowest_id),
        .respawn(respawn), .respawn_id(respawn_id), .state(state), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_div = 0; m_jt = 0; m_st = 0; m_low = 0; m_tgt = 0;
        m_rid = 0; m_first = 1; m_resp = 0;
    endtask

    function automatic bit m_tick();
        return (m_mode == 1 || m_mode == 2) && m_div == TD - 1;
    endfunction

    task automatic model_step();
        bit tk, fall, ok;
        int nj;
        tk = m_tick();
        fall = m_jt >= JT / 2;
        if (m_first && m_jt == JT) nj = 0;
        else nj = (m_jt + 1 > JMAX) ? JMAX : m_jt + 1;
        m_resp = 0;
        if (m_mode == 0 || m_mode == 3) begin
            if (start) begin
                m_mode = 1; m_div = 0; m_jt = 0; m_st = 0; m_low = 0; m_first = 1;
            end
        end else if (fall_out) begin
            m_mode = 3; m_div = 0;
        end else if (m_mode == 1) begin
            ok = fall && (land_id == m_low || (!m_first && land_id == (m_low + 1) % 4));
            if (land && ok) begin
                m_jt = 0; m_div = 0; m_st = 0;
                if (!(!m_first && land_id == m_low)) begin
                    m_mode = 2; m_tgt = land_id;
                end
            end else begin
                m_div = (m_div + 1) % TD;
                if (tk) m_jt = nj;
            end
        end else begin
            m_div = (m_div + 1) % TD;
            if (tk) begin
                m_jt = nj;
                if (m_st == ST - 1) begin
                    m_st = ST; m_mode = 1;
                    if (!m_first) begin m_resp = 1; m_rid = m_low; end
                    m_low = m_tgt; m_first = 0;
                end else m_st = m_st + 1;
            end
        end
    endtask

    task automatic check_all();
        check("state", state, m_mode);
        check("jump_t", jump_t, m_jt);
        check("scroll_t", scroll_t, m_st);
        check("lowest_id", lowest_id, m_low);
        check("respawn", respawn, m_resp);
        check("respawn_id", respawn_id, m_rid);
        check("tick", tick, m_tick());
        check("falling", falling, m_jt >= JT / 2);
        check("scroll_en", scroll_en, m_mode == 2);
        check("game_over", game_over, m_mode == 3);
    endtask

    task automatic cyc(input bit st, input bit ld, input int lid, input bit fo);
        @(negedge clk);
        start = st; land = ld; land_id = 2'(lid); fall_out = fo;
        @(posedge clk);
        model_step();
        #1 check_all();
    endtask

    task automatic wait_jt_ge(input int v);
        for (int i = 0; i < 400 && m_jt < v; i++) cyc(0, 0, 0, 0);
        check("wait_jump_t", 32'(jump_t >= JW'(v)), 1);
    endtask

    task automatic land_and_scroll(input int id);
        wait_jt_ge(7);
        cyc(0, 1, id, 0);
        check("enter_scroll", state, 2);
        for (int i = 0; i < 40 && m_mode == 2; i++) cyc(0, 0, 0, 0);
    endtask

    initial begin
        clk = 0; rst = 1; start = 0; land = 0; land_id = 0; fall_out = 0;
        model_reset();
        #12;
        check_all();
        check("rst_state", state, 0);
        @(negedge clk); rst = 0;

        // T1: ground bounce arc
        cyc(1, 0, 0, 0);
        check("t1_play", state, 1);
        for (int i = 0; i < 56; i++) cyc(0, 0, 0, 0);
        check("t1_jt14", jump_t, 14);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        check("t1_wrap", jump_t, 0);

        // T2: first landing lifts off the ground, no respawn
        wait_jt_ge(9);
        cyc(0, 1, 0, 0);
        check("t2_scroll", state, 2);
        check("t2_jt0", jump_t, 0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0);
        check("t2_play", state, 1);
        check("t2_st3", scroll_t, 3);
        check("t2_low0", lowest_id, 0);
        check("t2_noresp", respawn, 0);

        // T3: next platform up triggers respawn of the old lowest
        land_and_scroll(1);
        check("t3_low1", lowest_id, 1);
        check("t3_resp", respawn, 1);
        check("t3_rid0", respawn_id, 0);
        cyc(0, 0, 0, 0);
        check("t3_resp_1clk", respawn, 0);

        // T4: lands that must be ignored
        wait_jt_ge(3);
        cyc(0, 1, 1, 0);
        check("t4_rising", state, 1);
        wait_jt_ge(7);
        cyc(0, 1, 3, 0);
        check("t4_wrong_id", state, 1);

        // T5: ring wrap, then land+fall_out together
        land_and_scroll(2);
        land_and_scroll(3);
        check("t5_low3", lowest_id, 3);
        land_and_scroll(0);
        check("t5_low0", lowest_id, 0);
        check("t5_resp", respawn, 1);
        check("t5_rid3", respawn_id, 3);
        wait_jt_ge(7);
        cyc(0, 1, 1, 1);
        check("t5_over", state, 3);
        check("t5_go", game_over, 1);
        cyc(1, 0, 0, 0);
        check("t5_restart", state, 1);
        check("t5_restart_low", lowest_id, 0);

        // T6: async reset mid-scroll
        wait_jt_ge(7);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        check("t6_in_scroll", state, 2);
        @(negedge clk);
        #2 rst = 1;
        #1 model_reset();
        check_all();
        check("t6_state", state, 0);
        @(negedge clk); rst = 0;
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);

        // randomized play
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
                int'($urandom_range(0, 3)), $urandom_range(0, 199) == 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
